// File: rtl/pcm_receiver_if.sv
// Receiver-side output bundle of the PCM deframer.
// The receiver drives it as master; downstream logic listens as slave.
interface pcm_receiver_if;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic [15:0] byte_idx_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        frame_err_o;
    logic        sync_loss_o;
    logic        locked_o;
    logic [31:0] frame_cnt_o;

    modport master (
        output byte_o, byte_valid_o, byte_idx_o,
        output frame_start_o, frame_end_o, frame_err_o,
        output sync_loss_o, locked_o, frame_cnt_o
    );

    modport slave (
        input byte_o, byte_valid_o, byte_idx_o,
        input frame_start_o, frame_end_o, frame_err_o,
        input sync_loss_o, locked_o, frame_cnt_o
    );
endinterface

// File: rtl/pcm_receiver.sv
// Serial PCM frame receiver: syncs pcm_clk/pcm_data, hunts for the sync code,
// deframes MSB-first bytes and flywheels over isolated sync errors.
module pcm_receiver #(
    parameter int MISS_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        edge_i,
    input  logic [31:0] code_i,
    input  logic [1:0]  number_i,
    input  logic [15:0] length_i,
    input  logic        pcm_clk_i,
    input  logic        pcm_data_i,
    pcm_receiver_if.master rx
);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        VERIFY
    } state_t;

    state_t      state;
    logic [2:0]  pclk_q;
    logic [1:0]  pdat_q;
    logic [31:0] win;
    logic [5:0]  cnt;
    logic [7:0]  miss;
    logic [15:0] idx;
    logic        vpend;
    logic [31:0] cfg_code;
    logic [1:0]  cfg_num;
    logic [15:0] cfg_len;

    logic        rise;
    logic        fall;
    logic        take;
    logic        bit_in;
    logic [5:0]  w;
    logic [31:0] mask;
    logic [31:0] win_nx;
    logic        hit;
    logic        hit_nx;
    logic [15:0] last_idx;
    logic        hunt_ok;

    always_comb begin
        rise     = pclk_q[1] & ~pclk_q[2];
        fall     = ~pclk_q[1] & pclk_q[2];
        take     = edge_i ? rise : fall;
        bit_in   = pdat_q[1];
        w        = 6'd32 - {1'b0, cfg_num, 3'b000};
        mask     = 32'hFFFF_FFFF >> (6'd32 - w);
        win_nx   = {win[30:0], bit_in};
        hit      = (win & mask) == (cfg_code & mask);
        hit_nx   = (win_nx & mask) == (cfg_code & mask);
        last_idx = (cfg_len == 16'd0) ? 16'd0 : cfg_len - 16'd1;
        hunt_ok  = ({1'b0, cnt} + 7'd1) >= {1'b0, w};
    end

    // Two-stage synchronisers; pclk_q[2] is the extra edge-detect stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_q <= '0;
            pdat_q <= '0;
        end else begin
            pclk_q <= {pclk_q[1:0], pcm_clk_i};
            pdat_q <= {pdat_q[0], pcm_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= HUNT;
            win              <= '0;
            cnt              <= '0;
            miss             <= '0;
            idx              <= '0;
            vpend            <= 1'b0;
            cfg_code         <= code_i;
            cfg_num          <= number_i;
            cfg_len          <= length_i;
            rx.byte_o        <= '0;
            rx.byte_valid_o  <= 1'b0;
            rx.byte_idx_o    <= '0;
            rx.frame_start_o <= 1'b0;
            rx.frame_end_o   <= 1'b0;
            rx.frame_err_o   <= 1'b0;
            rx.sync_loss_o   <= 1'b0;
            rx.locked_o      <= 1'b0;
            rx.frame_cnt_o   <= '0;
        end else begin
            rx.byte_valid_o  <= 1'b0;
            rx.frame_start_o <= 1'b0;
            rx.frame_end_o   <= 1'b0;
            rx.frame_err_o   <= 1'b0;
            rx.sync_loss_o   <= 1'b0;
            if (!enable_i) begin
                state       <= HUNT;
                win         <= '0;
                cnt         <= '0;
                miss        <= '0;
                vpend       <= 1'b0;
                cfg_code    <= code_i;
                cfg_num     <= number_i;
                cfg_len     <= length_i;
                rx.locked_o <= 1'b0;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (take) begin
                            win <= win_nx;
                            if (cnt != 6'd32)
                                cnt <= cnt + 6'd1;
                            if (hit_nx && hunt_ok) begin
                                rx.frame_start_o <= 1'b1;
                                idx              <= '0;
                                cnt              <= '0;
                                state            <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (take) begin
                            win <= win_nx;
                            if (cnt[2:0] == 3'd7) begin
                                rx.byte_o       <= win_nx[7:0];
                                rx.byte_valid_o <= 1'b1;
                                rx.byte_idx_o   <= idx;
                                idx             <= idx + 16'd1;
                                cnt             <= '0;
                                if (idx == last_idx) begin
                                    rx.frame_end_o <= 1'b1;
                                    state          <= VERIFY;
                                end
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    VERIFY: begin
                        if (vpend) begin
                            vpend <= 1'b0;
                            cnt   <= '0;
                            idx   <= '0;
                            if (hit) begin
                                miss             <= '0;
                                rx.locked_o      <= 1'b1;
                                rx.frame_cnt_o   <= rx.frame_cnt_o + 32'd1;
                                rx.frame_start_o <= 1'b1;
                                state            <= DATA;
                            end else if ((miss + 8'd1) < 8'(MISS_MAX)) begin
                                // Flywheel: trust the frame timing over one bad sync.
                                miss             <= miss + 8'd1;
                                rx.frame_err_o   <= 1'b1;
                                rx.frame_start_o <= 1'b1;
                                state            <= DATA;
                            end else begin
                                miss           <= '0;
                                win            <= '0;
                                rx.sync_loss_o <= 1'b1;
                                rx.locked_o    <= 1'b0;
                                cfg_code       <= code_i;
                                cfg_num        <= number_i;
                                cfg_len        <= length_i;
                                state          <= HUNT;
                            end
                        end else if (take) begin
                            win <= win_nx;
                            cnt <= cnt + 6'd1;
                            if ((cnt + 6'd1) == w)
                                vpend <= 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcm_receiver.sv
// Directed bench for pcm_receiver: sync hunt, deframing, flywheel,
// sync loss and enable-abort, with hand-computed expected bytes.
module tb_pcm_receiver;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        edge_sel = 1'b0;
    logic [31:0] code = 32'h1ACF_FC1D;
    logic [1:0]  number = 2'd0;
    logic [15:0] length = 16'd4;
    logic        pcm_clk = 1'b0;
    logic        pcm_data = 1'b0;

    pcm_receiver_if rx_bus ();

    pcm_receiver #(.MISS_MAX(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .edge_i     (edge_sel),
        .code_i     (code),
        .number_i   (number),
        .length_i   (length),
        .pcm_clk_i  (pcm_clk),
        .pcm_data_i (pcm_data),
        .rx         (rx_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_end = 0;
    int n_err = 0;
    int n_loss = 0;
    int n_ovl = 0;
    logic [7:0]  bq[$];
    logic [15:0] iq[$];
    logic        lq[$];
    logic [31:0] fq[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_bus.byte_valid_o) begin
                bq.push_back(rx_bus.byte_o);
                iq.push_back(rx_bus.byte_idx_o);
            end
            if (rx_bus.frame_start_o) begin
                n_start++;
                lq.push_back(rx_bus.locked_o);
                fq.push_back(rx_bus.frame_cnt_o);
            end
            if (rx_bus.frame_end_o) n_end++;
            if (rx_bus.frame_err_o) n_err++;
            if (rx_bus.sync_loss_o) n_loss++;
            if ((int'(rx_bus.byte_valid_o) + int'(rx_bus.frame_start_o)
                 + int'(rx_bus.sync_loss_o)) > 1
                || (rx_bus.frame_end_o && !rx_bus.byte_valid_o)
                || (rx_bus.frame_err_o && !rx_bus.frame_start_o))
                n_ovl++;
        end
    end

    task automatic clear_log();
        bq.delete(); iq.delete(); lq.delete(); fq.delete();
        n_start = 0; n_end = 0; n_err = 0; n_loss = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pcm_clk = ~pcm_clk;
        end
        pcm_clk = ~edge_sel;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        clear_log();
    endtask

    task automatic send_bit(input logic b);
        pcm_data = b;
        pcm_clk = ~edge_sel;
        #(HALF);
        pcm_clk = edge_sel;
        #(HALF);
    endtask

    task automatic send_word(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic flush();
        repeat (14) @(negedge clk);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset while pcm_clk toggles
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pcm_clk = ~pcm_clk;
            if (i == 4) begin
                check("t1_byte", {24'd0, rx_bus.byte_o}, 32'd0);
                check("t1_idx", {16'd0, rx_bus.byte_idx_o}, 32'd0);
                check("t1_strobes", {27'd0, rx_bus.byte_valid_o,
                      rx_bus.frame_start_o, rx_bus.frame_end_o,
                      rx_bus.frame_err_o, rx_bus.sync_loss_o}, 32'd0);
                check("t1_locked", {31'd0, rx_bus.locked_o}, 32'd0);
                check("t1_fcnt", rx_bus.frame_cnt_o, 32'd0);
            end
        end

        // T2 32-bit sync, length 4, falling-edge sampling
        edge_sel = 1'b0; number = 2'd0; code = 32'h1ACF_FC1D; length = 16'd4;
        do_reset();
        send_word(code, 32);
        for (int i = 0; i < 4; i++) send_word(i, 8);
        send_word(code, 32);
        for (int i = 4; i < 8; i++) send_word(i, 8);
        flush();
        check("t2_nbytes", bq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_byte%0d", i), {24'd0, bq[i]}, i);
            check($sformatf("t2_idx%0d", i), {16'd0, iq[i]}, i % 4);
        end
        check("t2_nstart", n_start, 2);
        check("t2_nend", n_end, 2);
        check("t2_lock0", {31'd0, lq[0]}, 0);
        check("t2_lock1", {31'd0, lq[1]}, 1);
        check("t2_fcnt1", fq[1], 1);

        // T3 three leading junk bits
        do_reset();
        send_word($urandom_range(7, 0), 3);
        send_word(code, 32);
        for (int i = 0; i < 4; i++) send_word(i, 8);
        send_word(code, 32);
        for (int i = 4; i < 8; i++) send_word(i, 8);
        flush();
        check("t3_nbytes", bq.size(), 8);
        check("t3_first", {24'd0, bq[0]}, 32'h00);
        check("t3_idx0", {16'd0, iq[0]}, 0);
        check("t3_last", {24'd0, bq[7]}, 32'h07);
        check("t3_fcnt", rx_bus.frame_cnt_o, 1);

        // T4 8-bit sync, rising-edge sampling
        edge_sel = 1'b1; number = 2'd3; code = 32'h0000_00EB; length = 16'd2;
        do_reset();
        send_word(32'hEB, 8); send_word(32'hA5, 8); send_word(32'h3C, 8);
        send_word(32'hEB, 8); send_word(32'h5A, 8); send_word(32'hC3, 8);
        flush();
        check("t4_nbytes", bq.size(), 4);
        check("t4_b0", {24'd0, bq[0]}, 32'hA5);
        check("t4_b1", {24'd0, bq[1]}, 32'h3C);
        check("t4_b2", {24'd0, bq[2]}, 32'h5A);
        check("t4_b3", {24'd0, bq[3]}, 32'hC3);
        check("t4_idx3", {16'd0, iq[3]}, 1);
        check("t4_locked", {31'd0, rx_bus.locked_o}, 1);

        // T5 flywheel, miss clear, sync loss and reacquire
        do_reset();
        send_word(32'hEB, 8); send_word(32'h11, 8); send_word(32'h22, 8);
        send_word(32'hEB, 8); send_word(32'h33, 8); send_word(32'h44, 8);
        send_word(32'h00, 8); send_word(32'h55, 8); send_word(32'h66, 8);
        send_word(32'h00, 8); send_word(32'h77, 8); send_word(32'h88, 8);
        flush();
        check("t5_err2", n_err, 2);
        check("t5_lock_fly", {31'd0, rx_bus.locked_o}, 1);
        check("t5_nbytes", bq.size(), 8);
        check("t5_b7", {24'd0, bq[7]}, 32'h88);
        send_word(32'hEB, 8); send_word(32'h99, 8); send_word(32'hAA, 8);
        send_word(32'h00, 8); send_word(32'hBB, 8); send_word(32'hCC, 8);
        send_word(32'h00, 8); send_word(32'hDD, 8); send_word(32'hEE, 8);
        flush();
        check("t5_err4", n_err, 4);
        check("t5_noloss", n_loss, 0);
        check("t5_fcnt", rx_bus.frame_cnt_o, 2);
        send_word(32'h00, 8);
        flush();
        check("t5_loss", n_loss, 1);
        check("t5_unlock", {31'd0, rx_bus.locked_o}, 0);
        send_word(32'hEB, 8); send_word(32'h12, 8); send_word(32'h34, 8);
        flush();
        check("t5_re_nbytes", bq.size(), 16);
        check("t5_re_b0", {24'd0, bq[14]}, 32'h12);
        check("t5_re_idx", {16'd0, iq[14]}, 0);
        check("t5_re_fcnt", rx_bus.frame_cnt_o, 2);

        // T6 enable dropped mid-byte
        do_reset();
        send_word(32'hEB, 8); send_word(32'h01, 8); send_word(32'h02, 8);
        send_word(32'hEB, 8);
        send_word(32'h0, 4);
        @(negedge clk) enable = 1'b0;
        @(negedge clk) enable = 1'b1;
        send_word(32'h0, 4);
        flush();
        check("t6_nbytes", bq.size(), 2);
        check("t6_unlock", {31'd0, rx_bus.locked_o}, 0);
        check("t6_fcnt_hold", rx_bus.frame_cnt_o, 1);
        send_word(32'hEB, 8); send_word(32'h03, 8); send_word(32'h04, 8);
        send_word(32'hEB, 8); send_word(32'h05, 8); send_word(32'h06, 8);
        flush();
        check("t6_relock", {31'd0, rx_bus.locked_o}, 1);
        check("t6_fcnt", rx_bus.frame_cnt_o, 2);
        check("t6_b_last", {24'd0, bq[bq.size() - 1]}, 32'h06);

        check("strobe_overlap", n_ovl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
